// File: rtl/watch_time_editor.sv
// watch_time_editor: BCD time-of-day keeper with digit editing and a blink
// mask for the display driver. It sits downstream of the watch setting FSM.
//
// Timekeeping runs when i_blink_en=0. While i_blink_en=1 it freezes, the
// seconds are cleared and the selected digit can be edited. A selected digit
// wraps or clamps on its own and never carries into its neighbours.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   i_cursor    digit select: 0 idle, 1 H10, 2 H1, 3 M10, 4 M1, 5-7 invalid
//   i_blink_en  edit mode active
//   i_btn_up    single-cycle pulse, increment the selected digit
//   i_btn_down  single-cycle pulse, decrement the selected digit
//   o_h10..o_s1 registered BCD time digits
//   o_blank     registered blank mask, [3]=H10 [2]=H1 [1]=M10 [0]=M1
module watch_time_editor #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_cursor,
    input  logic       i_blink_en,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic [1:0] o_h10,
    output logic [3:0] o_h1,
    output logic [2:0] o_m10,
    output logic [3:0] o_m1,
    output logic [2:0] o_s10,
    output logic [3:0] o_s1,
    output logic [3:0] o_blank
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [1:0]    h10_q, h10_d;
    logic [3:0]    h1_q, h1_d;
    logic [2:0]    m10_q, m10_d;
    logic [3:0]    m1_q, m1_d;
    logic [2:0]    s10_q, s10_d;
    logic [3:0]    s1_q, s1_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          blink_en_q;
    logic [3:0]    blank_q, blank_d;

    logic       tick;
    logic       entry;
    logic       edit;
    logic [1:0] h10_new;
    logic [3:0] h1_limit;

    assign entry = i_blink_en & ~blink_en_q;
    assign edit  = i_blink_en & (i_btn_up ^ i_btn_down) &
                   (i_cursor >= 3'd1) & (i_cursor <= 3'd4);

    always_comb begin
        h10_d       = h10_q;
        h1_d        = h1_q;
        m10_d       = m10_q;
        m1_d        = m1_q;
        s10_d       = s10_q;
        s1_d        = s1_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = 4'b0000;
        tick        = 1'b0;
        h10_new     = h10_q;
        h1_limit    = (h10_q == 2'd2) ? 4'd3 : 4'd9;

        // Prescaler is parked at 0 during edit, so the first second after exit
        // is a full TICK_DIV cycles and a tick on the entry cycle is dropped.
        if (i_blink_en) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (entry) begin
            s10_d = 3'd0;
            s1_d  = 4'd0;
        end else if (tick) begin
            if (s1_q != 4'd9) begin
                s1_d = s1_q + 4'd1;
            end else begin
                s1_d = 4'd0;
                if (s10_q != 3'd5) begin
                    s10_d = s10_q + 3'd1;
                end else begin
                    s10_d = 3'd0;
                    if (m1_q != 4'd9) begin
                        m1_d = m1_q + 4'd1;
                    end else begin
                        m1_d = 4'd0;
                        if (m10_q != 3'd5) begin
                            m10_d = m10_q + 3'd1;
                        end else begin
                            m10_d = 3'd0;
                            if (h10_q == 2'd2 && h1_q == 4'd3) begin
                                h10_d = 2'd0;
                                h1_d  = 4'd0;
                            end else if (h1_q == 4'd9) begin
                                h1_d  = 4'd0;
                                h10_d = h10_q + 2'd1;
                            end else begin
                                h1_d = h1_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end

        if (edit) begin
            case (i_cursor)
                3'd1: begin
                    if (i_btn_up) h10_new = (h10_q == 2'd2) ? 2'd0 : h10_q + 2'd1;
                    else          h10_new = (h10_q == 2'd0) ? 2'd2 : h10_q - 2'd1;
                    h10_d = h10_new;
                    // Keep the hour legal when moving into the 20s.
                    if (h10_new == 2'd2 && h1_q > 4'd3) h1_d = 4'd3;
                end
                3'd2: begin
                    if (i_btn_up) h1_d = (h1_q == h1_limit) ? 4'd0 : h1_q + 4'd1;
                    else          h1_d = (h1_q == 4'd0) ? h1_limit : h1_q - 4'd1;
                end
                3'd3: begin
                    if (i_btn_up) m10_d = (m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1;
                    else          m10_d = (m10_q == 3'd0) ? 3'd5 : m10_q - 3'd1;
                end
                3'd4: begin
                    if (i_btn_up) m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
                    else          m1_d = (m1_q == 4'd0) ? 4'd9 : m1_q - 4'd1;
                end
                default: ;
            endcase
        end

        // An accepted edit restarts the blink so the digit stays visible.
        if (!i_blink_en || edit) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        if (i_blink_en && phase_d) begin
            case (i_cursor)
                3'd1:    blank_d = 4'b1000;
                3'd2:    blank_d = 4'b0100;
                3'd3:    blank_d = 4'b0010;
                3'd4:    blank_d = 4'b0001;
                default: blank_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h10_q       <= 2'd0;
            h1_q        <= 4'd0;
            m10_q       <= 3'd0;
            m1_q        <= 4'd0;
            s10_q       <= 3'd0;
            s1_q        <= 4'd0;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_en_q  <= 1'b0;
            blank_q     <= 4'b0000;
        end else begin
            h10_q       <= h10_d;
            h1_q        <= h1_d;
            m10_q       <= m10_d;
            m1_q        <= m1_d;
            s10_q       <= s10_d;
            s1_q        <= s1_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blink_en_q  <= i_blink_en;
            blank_q     <= blank_d;
        end
    end

    assign o_h10   = h10_q;
    assign o_h1    = h1_q;
    assign o_m10   = m10_q;
    assign o_m1    = m1_q;
    assign o_s10   = s10_q;
    assign o_s1    = s1_q;
    assign o_blank = blank_q;

endmodule
